snake_body_ctrl: RTL and testbench

Movement and body-tracking stage that sits directly downstream of the key-detect block. On each step tick it consumes the one-hot `dir` and the `reset` pulse produced by that block and advances the snake one grid cell. It tracks up to `MAX_LEN` body segments, grows the snake when it eats an apple, and detects wall and self collisions. A registered query port lets the VGA renderer ask whether a given grid cell holds snake head or body.

---
 rtl/snake_body_ctrl_if.sv | 38 +++
 rtl/snake_body_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_snake_body_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/snake_body_ctrl_if.sv
// Bundles the movement-stage control, apple, query and status signals
// between key detect / renderer (master side) and the body controller.
interface snake_body_ctrl_if #(
    parameter int X_W = 6,
    parameter int Y_W = 5
);
    logic [3:0]     dir;
    logic           game_reset;
    logic           step_tick;
    logic [X_W-1:0] apple_x;
    logic [Y_W-1:0] apple_y;
    logic           apple_valid;
    logic [X_W-1:0] query_x;
    logic [Y_W-1:0] query_y;
    logic [X_W-1:0] head_x;
    logic [Y_W-1:0] head_y;
    logic [4:0]     length;
    logic           apple_eaten;
    logic           game_over;
    logic           head_hit;
    logic           body_hit;

    modport master (
        output dir, game_reset, step_tick,
        output apple_x, apple_y, apple_valid,
        output query_x, query_y,
        input  head_x, head_y, length,
        input  apple_eaten, game_over, head_hit, body_hit
    );

    modport slave (
        input  dir, game_reset, step_tick,
        input  apple_x, apple_y, apple_valid,
        input  query_x, query_y,
        output head_x, head_y, length,
        output apple_eaten, game_over, head_hit, body_hit
    );
endinterface

// File: rtl/snake_body_ctrl.sv
// Snake movement and body tracking: advances the head one cell per step
// tick, grows on apple, detects wall/self collisions and answers
// renderer cell queries with one cycle of latency.
module snake_body_ctrl #(
    parameter int GRID_W   = 40,
    parameter int GRID_H   = 30,
    parameter int MAX_LEN  = 16,
    parameter int INIT_LEN = 3,
    parameter int X_W      = 6,
    parameter int Y_W      = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    snake_body_ctrl_if.slave bus
);

    localparam logic [3:0] DIR_UP    = 4'b1000;
    localparam logic [3:0] DIR_DOWN  = 4'b0100;
    localparam logic [3:0] DIR_LEFT  = 4'b0010;
    localparam logic [3:0] DIR_RIGHT = 4'b0001;

    typedef enum logic {RUN, DEAD} state_t;

    state_t         state;
    state_t         state_next;

    logic [X_W-1:0] seg_x [MAX_LEN];
    logic [Y_W-1:0] seg_y [MAX_LEN];
    logic [4:0]     len_q;
    logic [3:0]     cur_dir;
    logic           apple_eaten_q;
    logic           head_hit_q;
    logic           body_hit_q;

    logic [3:0]     sel_dir;
    logic [X_W-1:0] next_x;
    logic [Y_W-1:0] next_y;
    logic           wall_hit;
    logic           eat;
    logic [4:0]     cmp_len;
    logic           self_hit;
    logic           tick_run;
    logic           move_ok;
    logic           body_match;

    // The direction directly opposite d (UP<->DOWN, LEFT<->RIGHT).
    function automatic logic [3:0] opposite(input logic [3:0] d);
        return {d[2], d[3], d[0], d[1]};
    endfunction

    // Direction select, next head, wall/apple/self checks and next FSM state.
    always_comb begin
        sel_dir    = cur_dir;
        next_x     = seg_x[0];
        next_y     = seg_y[0];
        wall_hit   = 1'b0;
        eat        = 1'b0;
        cmp_len    = len_q - 5'd1;
        self_hit   = 1'b0;
        tick_run   = 1'b0;
        move_ok    = 1'b0;
        state_next = state;

        if ($onehot(bus.dir) && (bus.dir != opposite(cur_dir))) begin
            sel_dir = bus.dir;
        end

        // Edge test uses the current head so the +/-1 below never wraps into play.
        case (sel_dir)
            DIR_UP: begin
                wall_hit = (seg_y[0] == '0);
                next_y   = seg_y[0] - Y_W'(1);
            end
            DIR_DOWN: begin
                wall_hit = (seg_y[0] == Y_W'(GRID_H - 1));
                next_y   = seg_y[0] + Y_W'(1);
            end
            DIR_LEFT: begin
                wall_hit = (seg_x[0] == '0);
                next_x   = seg_x[0] - X_W'(1);
            end
            default: begin
                wall_hit = (seg_x[0] == X_W'(GRID_W - 1));
                next_x   = seg_x[0] + X_W'(1);
            end
        endcase

        eat = bus.apple_valid && (next_x == bus.apple_x) && (next_y == bus.apple_y);

        // Without growth the tail leaves its cell, so it is excluded from the check.
        if (eat) begin
            cmp_len = len_q;
        end
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((i < int'(cmp_len)) && (seg_x[i] == next_x) && (seg_y[i] == next_y)) begin
                self_hit = 1'b1;
            end
        end

        tick_run = bus.step_tick && (state == RUN) && !bus.game_reset;
        move_ok  = tick_run && !wall_hit && !self_hit;

        if (bus.game_reset) begin
            state_next = RUN;
        end else if (tick_run && (wall_hit || self_hit)) begin
            state_next = DEAD;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Segment shift, direction latch, growth and the eat pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x[i] <= X_W'(GRID_W / 2 - i);
                seg_y[i] <= Y_W'(GRID_H / 2);
            end
            len_q         <= 5'(INIT_LEN);
            cur_dir       <= DIR_RIGHT;
            apple_eaten_q <= 1'b0;
        end else if (bus.game_reset) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x[i] <= X_W'(GRID_W / 2 - i);
                seg_y[i] <= Y_W'(GRID_H / 2);
            end
            len_q         <= 5'(INIT_LEN);
            cur_dir       <= DIR_RIGHT;
            apple_eaten_q <= 1'b0;
        end else begin
            apple_eaten_q <= 1'b0;
            if (move_ok) begin
                for (int i = MAX_LEN - 1; i > 0; i--) begin
                    seg_x[i] <= seg_x[i-1];
                    seg_y[i] <= seg_y[i-1];
                end
                seg_x[0] <= next_x;
                seg_y[0] <= next_y;
                cur_dir  <= sel_dir;
                if (eat) begin
                    apple_eaten_q <= 1'b1;
                    if (len_q < 5'(MAX_LEN)) begin
                        len_q <= len_q + 5'd1;
                    end
                end
            end
        end
    end

    // Query cell against live body segments 1..length-1 only.
    always_comb begin
        body_match = 1'b0;
        for (int i = 1; i < MAX_LEN; i++) begin
            if ((i < int'(len_q)) && (seg_x[i] == bus.query_x) && (seg_y[i] == bus.query_y)) begin
                body_match = 1'b1;
            end
        end
    end

    // Registered renderer query results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_hit_q <= 1'b0;
            body_hit_q <= 1'b0;
        end else if (bus.game_reset) begin
            head_hit_q <= 1'b0;
            body_hit_q <= 1'b0;
        end else begin
            head_hit_q <= (bus.query_x == seg_x[0]) && (bus.query_y == seg_y[0]);
            body_hit_q <= body_match;
        end
    end

    assign bus.head_x      = seg_x[0];
    assign bus.head_y      = seg_y[0];
    assign bus.length      = len_q;
    assign bus.apple_eaten = apple_eaten_q;
    assign bus.game_over   = (state == DEAD);
    assign bus.head_hit    = head_hit_q;
    assign bus.body_hit    = body_hit_q;

endmodule

// File: tb/tb_snake_body_ctrl.sv
// Directed bench for snake_body_ctrl: reset, straight run into the wall,
// growth and saturation, direction filtering, self-collision vs tail
// chase, and reset/tick interactions.
module tb_snake_body_ctrl;

    localparam logic [3:0] UP    = 4'b1000;
    localparam logic [3:0] DOWN  = 4'b0100;
    localparam logic [3:0] LEFT  = 4'b0010;
    localparam logic [3:0] RIGHT = 4'b0001;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   tests_run    = 0;
    int   tests_failed = 0;

    snake_body_ctrl_if #(.X_W(6), .Y_W(5)) bus ();

    snake_body_ctrl #(
        .GRID_W(40), .GRID_H(30), .MAX_LEN(16), .INIT_LEN(3), .X_W(6), .Y_W(5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic checkHead(input string tag, input int ex, input int ey);
        checkOutput({tag, "_x"}, 32'(bus.head_x), 32'(ex));
        checkOutput({tag, "_y"}, 32'(bus.head_y), 32'(ey));
    endtask

    // One clock of stimulus applied at a falling edge; returns at the next falling edge.
    task automatic applyStimulus(input logic [3:0] d, input logic tick, input logic grst);
        @(negedge clk);
        bus.dir        = d;
        bus.step_tick  = tick;
        bus.game_reset = grst;
        @(negedge clk);
        bus.step_tick  = 1'b0;
        bus.game_reset = 1'b0;
    endtask

    initial begin
        bus.dir         = RIGHT;
        bus.step_tick   = 1'b0;
        bus.game_reset  = 1'b0;
        bus.apple_x     = '0;
        bus.apple_y     = '0;
        bus.apple_valid = 1'b0;
        bus.query_x     = 6'd18;
        bus.query_y     = 5'd15;

        // Reset state
        repeat (3) @(negedge clk);
        checkHead("rst_head", 20, 15);
        checkOutput("rst_len", 32'(bus.length), 3);
        checkOutput("rst_over", 32'(bus.game_over), 0);
        checkOutput("rst_bhit", 32'(bus.body_hit), 0);
        rst_n = 1'b1;

        applyStimulus(RIGHT, 1'b0, 1'b0);
        checkOutput("q_18_body", 32'(bus.body_hit), 1);
        checkOutput("q_18_head", 32'(bus.head_hit), 0);
        bus.query_x = 6'd17;
        applyStimulus(RIGHT, 1'b0, 1'b0);
        checkOutput("q_17_body", 32'(bus.body_hit), 0);
        bus.query_x = 6'd20;
        applyStimulus(RIGHT, 1'b0, 1'b0);
        checkOutput("q_20_head", 32'(bus.head_hit), 1);
        checkOutput("q_20_body", 32'(bus.body_hit), 0);
        bus.query_x = 6'd19;
        applyStimulus(RIGHT, 1'b0, 1'b0);
        checkOutput("q_19_body", 32'(bus.body_hit), 1);

        // Straight run into the right wall
        for (int k = 0; k < 19; k++) applyStimulus(RIGHT, 1'b1, 1'b0);
        checkHead("run19", 39, 15);
        checkOutput("run19_over", 32'(bus.game_over), 0);
        applyStimulus(RIGHT, 1'b1, 1'b0);
        checkOutput("wall_over", 32'(bus.game_over), 1);
        checkHead("wall_head", 39, 15);
        applyStimulus(UP, 1'b1, 1'b0);
        checkHead("dead_hold", 39, 15);
        checkOutput("dead_over", 32'(bus.game_over), 1);
        checkOutput("dead_len", 32'(bus.length), 3);
        applyStimulus(RIGHT, 1'b0, 1'b1);
        checkHead("grst_head", 20, 15);
        checkOutput("grst_over", 32'(bus.game_over), 0);

        // Eat and grow
        bus.apple_x = 6'd21; bus.apple_y = 5'd15; bus.apple_valid = 1'b1;
        applyStimulus(RIGHT, 1'b1, 1'b0);
        checkHead("eat_head", 21, 15);
        checkOutput("eat_pulse", 32'(bus.apple_eaten), 1);
        checkOutput("eat_len", 32'(bus.length), 4);
        bus.query_x = 6'd18; bus.query_y = 5'd15;
        applyStimulus(RIGHT, 1'b0, 1'b0);
        checkOutput("eat_pulse_end", 32'(bus.apple_eaten), 0);
        checkOutput("eat_tail", 32'(bus.body_hit), 1);
        bus.query_x = 6'd17;
        applyStimulus(RIGHT, 1'b0, 1'b0);
        checkOutput("stale_seg", 32'(bus.body_hit), 0);
        for (int k = 0; k < 12; k++) begin
            bus.apple_x = 6'(22 + k);
            applyStimulus(RIGHT, 1'b1, 1'b0);
            checkOutput("grow_pulse", 32'(bus.apple_eaten), 1);
        end
        checkOutput("grow_len16", 32'(bus.length), 16);
        checkHead("grow_head", 33, 15);
        bus.apple_x = 6'd34;
        applyStimulus(RIGHT, 1'b1, 1'b0);
        checkOutput("sat_pulse", 32'(bus.apple_eaten), 1);
        checkOutput("sat_len", 32'(bus.length), 16);
        checkHead("sat_head", 34, 15);
        bus.apple_valid = 1'b0;
        applyStimulus(RIGHT, 1'b0, 1'b1);
        checkOutput("sat_grst_len", 32'(bus.length), 3);

        // Reversal and invalid direction
        applyStimulus(LEFT, 1'b1, 1'b0);
        checkHead("rev_left", 21, 15);
        applyStimulus(4'b0110, 1'b1, 1'b0);
        checkHead("bad_dir", 22, 15);
        applyStimulus(UP, 1'b1, 1'b0);
        checkHead("turn_up", 22, 14);
        applyStimulus(DOWN, 1'b1, 1'b0);
        checkHead("rev_down", 22, 13);
        applyStimulus(LEFT, 1'b0, 1'b0);
        checkHead("no_tick", 22, 13);
        applyStimulus(RIGHT, 1'b0, 1'b1);

        // Length-5 closed loop into own body
        bus.apple_valid = 1'b1; bus.apple_x = 6'd21; bus.apple_y = 5'd15;
        applyStimulus(RIGHT, 1'b1, 1'b0);
        bus.apple_x = 6'd22;
        applyStimulus(RIGHT, 1'b1, 1'b0);
        bus.apple_valid = 1'b0;
        checkOutput("loop5_len", 32'(bus.length), 5);
        applyStimulus(DOWN, 1'b1, 1'b0);
        applyStimulus(LEFT, 1'b1, 1'b0);
        checkHead("loop5_pre", 21, 16);
        applyStimulus(UP, 1'b1, 1'b0);
        checkOutput("loop5_over", 32'(bus.game_over), 1);
        checkHead("loop5_hold", 21, 16);
        applyStimulus(RIGHT, 1'b0, 1'b1);

        // Length-4 tail chase in a 2x2 square
        bus.apple_valid = 1'b1; bus.apple_x = 6'd21; bus.apple_y = 5'd15;
        applyStimulus(RIGHT, 1'b1, 1'b0);
        bus.apple_valid = 1'b0;
        applyStimulus(UP, 1'b1, 1'b0);
        applyStimulus(LEFT, 1'b1, 1'b0);
        applyStimulus(DOWN, 1'b1, 1'b0);
        checkOutput("chase_d_over", 32'(bus.game_over), 0);
        checkHead("chase_d", 20, 15);
        applyStimulus(RIGHT, 1'b1, 1'b0);
        checkHead("chase_r", 21, 15);
        applyStimulus(UP, 1'b1, 1'b0);
        checkHead("chase_u", 21, 14);
        applyStimulus(LEFT, 1'b1, 1'b0);
        checkHead("chase_l", 20, 14);
        checkOutput("chase_over", 32'(bus.game_over), 0);
        checkOutput("chase_len", 32'(bus.length), 4);

        // Same square, apple on the tail cell
        bus.apple_valid = 1'b1; bus.apple_x = 6'd20; bus.apple_y = 5'd15;
        applyStimulus(DOWN, 1'b1, 1'b0);
        checkOutput("tail_apple_over", 32'(bus.game_over), 1);
        checkOutput("tail_apple_eat", 32'(bus.apple_eaten), 0);
        checkHead("tail_apple_hold", 20, 14);
        checkOutput("tail_apple_len", 32'(bus.length), 4);
        bus.apple_valid = 1'b0;
        applyStimulus(RIGHT, 1'b0, 1'b1);

        // game_reset and step_tick together
        applyStimulus(RIGHT, 1'b1, 1'b0);
        checkHead("pre_both", 21, 15);
        applyStimulus(RIGHT, 1'b1, 1'b1);
        checkHead("both_head", 20, 15);
        checkOutput("both_len", 32'(bus.length), 3);

        // Asynchronous rst_n between ticks
        applyStimulus(RIGHT, 1'b1, 1'b0);
        checkHead("pre_arst", 21, 15);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkHead("arst_head", 20, 15);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(RIGHT, 1'b0, 1'b0);
        checkHead("arst_no_move", 20, 15);
        applyStimulus(RIGHT, 1'b1, 1'b0);
        checkHead("arst_fresh", 21, 15);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
